led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Parametrised LED pattern sequencer driving a WIDTH-bit LED bank.
- Advances one pattern step per programmable tick.
- Four selectable patterns: converge/diverge, chase, ping-pong, blink.
- Sits between board-level enable/mode controls and the LED pins; replaces fixed 8-bit, one-step-per-clock pattern logic.

Parameters:
- WIDTH, 8, number of LEDs. Legal range is 2 or more; odd values are legal.
- DIV_W, 24, width of the step-rate divider input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- en  input  1  run enable; synchronous, level-sensitive
- mode  input  2  pattern select: 0=converge/diverge, 1=chase, 2=ping-pong, 3=blink
- div  input  DIV_W  step period minus 1, in clk cycles (0 = one step per clk)
- led  output  WIDTH  registered LED drive, active-high
- step_pulse  output  1  registered, 1-cycle high on every cycle led takes a new step value
- frame_done  output  1  registered, 1-cycle high coincident with step_pulse when the last step of a frame is output

Behaviour:
- Reset (async, rst_n=0): led=0, step_pulse=0, frame_done=0, prescale count=0, step index=0, latched mode=0.
- Prescaler:
  - While en=1, cnt increments every clk.
  - When cnt>=div: tick fires and cnt<=0.
  - The >= comparison makes a div reduced below the current cnt produce a tick on the next cycle, with no wrap-through.
- Step latency: after en rises, the first led update occurs on the (div+1)-th rising edge with en=1.
- On tick:
  - If mode != latched mode: latch mode, step index=0, led<=pattern(new mode, 0).
  - Otherwise led<=pattern(latched mode, step), and step advances, wrapping to 0 after the last step of the frame.
  - step_pulse=1 for that cycle.
  - frame_done=1 if the step just output is the frame's last.
- Patterns, with H=(WIDTH+1)/2 (integer division) and bit i lit meaning led[i]=1:
  - Mode 0, converge/diverge: length 2H.
    - Steps k=0..H-1 light bits k and WIDTH-1-k (a single bit when they coincide, odd WIDTH middle).
    - Steps k=H..2H-2 mirror back, lighting the pair at index 2H-2-k.
    - Step 2H-1 is all zeros.
    - WIDTH=8 gives 81,42,24,18,24,42,81,00 (hex).
  - Mode 1, chase: length WIDTH; step k lights bit k only (LSB first), then wraps.
  - Mode 2, ping-pong: length 2*WIDTH-2; bit k for k=0..WIDTH-1, then bit 2*WIDTH-2-k. Endpoints are not repeated.
  - Mode 3, blink: length 2; step 0 all ones, step 1 all zeros.
- en=0, checked every cycle with priority over tick:
  - Next edge: led<=0, cnt<=0, step index<=0, step_pulse=0, frame_done=0.
  - The latched mode is retained.
  - Re-enabling restarts at step 0 after div+1 cycles.
- mode and div are sampled only at tick and compare time respectively; changes between ticks have no effect on led.
- div changes take effect at the next compare.
- Outputs never glitch: all outputs come straight from flops.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, operation resumes as from power-on.

Test Plan:
- WIDTH=8, div=0, mode=0, en=1 after reset -> led sequence 81,42,24,18,24,42,81,00 on consecutive cycles, repeating. frame_done high only with 00. step_pulse high every cycle.
- WIDTH=8, div=3, mode=1 -> led changes every 4 cycles. The first change (01) lands on the 4th edge after en rises. Sequence 01,02,04,...,80,01. frame_done with 80.
- WIDTH=5, div=0, mode=0 -> 11,0A,04,0A,11,00. Mode 2 -> 01,02,04,08,10,08,04,02, then repeats, with frame_done on 02.
- Mode switch 1->3 mid-frame at div=2 -> the next tick outputs FF (step 0 of blink), then 00, FF. No intermediate chase value.
- en dropped mid-frame (mode 0, led=24) -> led=00 the next cycle, no step_pulse. On re-enable with div=1, led=81 on the 2nd edge.
- rst_n pulsed low asynchronously between edges while led=42 -> led, step_pulse, frame_done go to 0 immediately. Sequence restarts from step 0 with mode 0 after release.

Source files
------------

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps a WIDTH-bit LED bank through one of four
// patterns, one step per programmable prescaler tick.
module led_pattern_seq #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             step_pulse,
    output logic             frame_done
);

    localparam int H  = (WIDTH + 1) / 2;
    localparam int SW = $clog2(2 * WIDTH);

    logic [DIV_W-1:0] r_cnt;
    logic [SW-1:0]    r_step;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_led;
    logic             r_step_pulse;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_switch;
    logic [1:0]       w_sel_mode;
    logic [SW-1:0]    w_sel_step;
    logic [SW-1:0]    w_next_step;
    logic [WIDTH-1:0] w_pat;
    logic             w_is_last;

    function automatic logic [WIDTH-1:0] f_pattern(input logic [1:0] m, input int k);
        logic [WIDTH-1:0] p;
        int               j;
        p = '0;
        j = 0;
        case (m)
            2'd0: begin
                j = (k < H) ? k : (2 * H - 2 - k);
                if (k <= 2 * H - 2) begin
                    for (int i = 0; i < WIDTH; i++)
                        if (i == j || i == WIDTH - 1 - j) p[i] = 1'b1;
                end
            end
            2'd1: begin
                for (int i = 0; i < WIDTH; i++)
                    if (i == k) p[i] = 1'b1;
            end
            2'd2: begin
                j = (k < WIDTH) ? k : (2 * WIDTH - 2 - k);
                for (int i = 0; i < WIDTH; i++)
                    if (i == j) p[i] = 1'b1;
            end
            default: begin
                if (k == 0) p = '1;
            end
        endcase
        return p;
    endfunction

    function automatic int f_last(input logic [1:0] m);
        case (m)
            2'd0:    return 2 * H - 1;
            2'd1:    return WIDTH - 1;
            2'd2:    return 2 * WIDTH - 3;
            default: return 1;
        endcase
    endfunction

    // A mode change restarts the frame: the tick outputs step 0 of the new
    // pattern, so r_step always holds the index of the next step to show.
    always_comb begin
        w_tick      = (r_cnt >= div);
        w_switch    = (mode != r_mode);
        w_sel_mode  = w_switch ? mode : r_mode;
        w_sel_step  = w_switch ? '0 : r_step;
        w_pat       = f_pattern(w_sel_mode, int'(w_sel_step));
        w_is_last   = (int'(w_sel_step) == f_last(w_sel_mode));
        w_next_step = w_is_last ? '0 : (w_sel_step + SW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_step       <= '0;
            r_mode       <= 2'd0;
            r_led        <= '0;
            r_step_pulse <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_cnt        <= '0;
            r_step       <= '0;
            r_led        <= '0;
            r_step_pulse <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (w_tick) begin
            r_cnt        <= '0;
            r_mode       <= w_sel_mode;
            r_step       <= w_next_step;
            r_led        <= w_pat;
            r_step_pulse <= 1'b1;
            r_frame_done <= w_is_last;
        end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_step_pulse <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign led        = r_led;
    assign step_pulse = r_step_pulse;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: WIDTH=8 and WIDTH=5 instances sharing
// clock and reset, checked against hand-computed LED values.
module tb_led_pattern_seq;

    logic       clk;
    logic       rst_n;
    logic       en8, en5;
    logic [1:0] mode8, mode5;
    logic [23:0] div8, div5;
    logic [7:0] led8;
    logic [4:0] led5;
    logic       sp8, fd8, sp5, fd5;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_m0_w8 [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81, 8'h00};
    logic [4:0] exp_m0_w5 [6] = '{5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h00};
    logic [4:0] exp_m2_w5 [9] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01};

    led_pattern_seq #(.WIDTH(8), .DIV_W(24)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .div(div8),
        .led(led8), .step_pulse(sp8), .frame_done(fd8)
    );

    led_pattern_seq #(.WIDTH(5), .DIV_W(24)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .div(div5),
        .led(led5), .step_pulse(sp5), .frame_done(fd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] l, input logic s, input logic f);
        chk({tag, " led"}, {24'h0, led8}, {24'h0, l});
        chk({tag, " step_pulse"}, {31'h0, sp8}, {31'h0, s});
        chk({tag, " frame_done"}, {31'h0, fd8}, {31'h0, f});
    endtask

    task automatic chk5(input string tag, input logic [4:0] l, input logic s, input logic f);
        chk({tag, " led"}, {27'h0, led5}, {27'h0, l});
        chk({tag, " step_pulse"}, {31'h0, sp5}, {31'h0, s});
        chk({tag, " frame_done"}, {31'h0, fd5}, {31'h0, f});
    endtask

    initial begin
        rst_n = 1'b0;
        en8 = 1'b0; mode8 = 2'd0; div8 = 24'd0;
        en5 = 1'b0; mode5 = 2'd0; div5 = 24'd0;
        #12;
        chk8("reset w8", 8'h00, 1'b0, 1'b0);
        chk5("reset w5", 5'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        edges(1);
        chk8("idle w8", 8'h00, 1'b0, 1'b0);

        // Converge/diverge, one step per clock, two full frames.
        en8 = 1'b1; mode8 = 2'd0; div8 = 24'd0;
        for (int i = 0; i < 16; i++) begin
            edges(1);
            chk8($sformatf("m0 w8 step%0d", i), exp_m0_w8[i % 8], 1'b1, (i % 8) == 7);
        end

        // Chase with div=3 after a fresh enable.
        en8 = 1'b0;
        edges(1);
        chk8("en low", 8'h00, 1'b0, 1'b0);
        en8 = 1'b1; mode8 = 2'd1; div8 = 24'd3;
        for (int k = 0; k < 9; k++) begin
            for (int w = 0; w < 3; w++) begin
                edges(1);
                chk8($sformatf("m1 hold%0d.%0d", k, w), (k == 0) ? 8'h00 : (8'h01 << ((k - 1) % 8)), 1'b0, 1'b0);
            end
            edges(1);
            chk8($sformatf("m1 tick%0d", k), 8'h01 << (k % 8), 1'b1, (k % 8) == 7);
        end

        // Switch chase -> blink at div=2.
        div8 = 24'd2;
        edges(3);
        chk8("m1 div2 tick", 8'h02, 1'b1, 1'b0);
        mode8 = 2'd3;
        edges(1);
        chk8("m3 hold a", 8'h02, 1'b0, 1'b0);
        edges(1);
        chk8("m3 hold b", 8'h02, 1'b0, 1'b0);
        edges(1);
        chk8("m3 step0", 8'hFF, 1'b1, 1'b0);
        edges(3);
        chk8("m3 step1", 8'h00, 1'b1, 1'b1);
        edges(3);
        chk8("m3 step0 again", 8'hFF, 1'b1, 1'b0);

        // Back to converge/diverge, drop enable at 24.
        mode8 = 2'd0; div8 = 24'd0;
        edges(1);
        chk8("m0 restart 81", 8'h81, 1'b1, 1'b0);
        edges(1);
        chk8("m0 restart 42", 8'h42, 1'b1, 1'b0);
        edges(1);
        chk8("m0 restart 24", 8'h24, 1'b1, 1'b0);
        en8 = 1'b0;
        edges(1);
        chk8("en drop", 8'h00, 1'b0, 1'b0);
        en8 = 1'b1; div8 = 24'd1;
        edges(1);
        chk8("reen edge1", 8'h00, 1'b0, 1'b0);
        edges(1);
        chk8("reen edge2", 8'h81, 1'b1, 1'b0);
        edges(2);
        chk8("reen edge4", 8'h42, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async reset", 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        edges(1);
        chk8("post reset edge1", 8'h00, 1'b0, 1'b0);
        edges(1);
        chk8("post reset edge2", 8'h81, 1'b1, 1'b0);
        en8 = 1'b0;

        // WIDTH=5: converge/diverge then ping-pong.
        en5 = 1'b1; mode5 = 2'd0; div5 = 24'd0;
        for (int i = 0; i < 6; i++) begin
            edges(1);
            chk5($sformatf("m0 w5 step%0d", i), exp_m0_w5[i], 1'b1, i == 5);
        end
        mode5 = 2'd2;
        for (int i = 0; i < 9; i++) begin
            edges(1);
            chk5($sformatf("m2 w5 step%0d", i), exp_m2_w5[i], 1'b1, i == 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
